// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid data-memory port, lane steering and load extension.
// Optional LSU_PERF_CNT_EN adds stall and completed-access counters (ports tied to 0 otherwise).
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_result_i,
    input  logic [31:0] mem_rs2_data_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic        mem_mem_read_i,
    input  logic        mem_mem_write_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] mem_load_data_o,
    output logic        mem_load_valid_o,
    output logic        mem_stall_o,
    output logic        mem_misaligned_o,
    output logic        mem_timeout_o,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_access_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_load_data;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic        r_we, r_valid, r_timeout;

    logic        w_fault, w_access;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ext;
    logic [7:0]  w_byte, w_cnt_nxt;
    logic [15:0] w_half;

    always_comb begin
        w_fault = 1'b0;
        case (mem_funct3_i)
            3'b000:  w_fault = 1'b0;
            3'b001:  w_fault = mem_alu_result_i[0];
            3'b010:  w_fault = (mem_alu_result_i[1:0] != 2'b00);
            3'b100:  w_fault = mem_mem_write_i;
            3'b101:  w_fault = mem_mem_write_i | mem_alu_result_i[0];
            default: w_fault = 1'b1;
        endcase
        w_access = (mem_mem_read_i | mem_mem_write_i) & ~w_fault & ~rst;
    end

    always_comb begin
        case (mem_funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << mem_alu_result_i[1:0];
                w_wdata = {4{mem_rs2_data_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << mem_alu_result_i[1:0];
                w_wdata = {2{mem_rs2_data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = mem_rs2_data_i;
            end
        endcase
    end

    // Extension uses the captured address/size, since the bus response arrives after IDLE.
    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = dmem_rdata_i[7:0];
            2'd1:    w_byte = dmem_rdata_i[15:8];
            2'd2:    w_byte = dmem_rdata_i[23:16];
            default: w_byte = dmem_rdata_i[31:24];
        endcase
        w_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        dmem_req_o       = 1'b0;
        dmem_we_o        = 1'b0;
        dmem_addr_o      = 32'd0;
        dmem_wdata_o     = 32'd0;
        dmem_be_o        = 4'd0;
        mem_stall_o      = 1'b0;
        mem_misaligned_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                mem_misaligned_o = (mem_mem_read_i | mem_mem_write_i) & w_fault & ~rst;
                if (w_access) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = mem_mem_write_i;
                    dmem_addr_o  = {mem_alu_result_i[31:2], 2'b00};
                    dmem_wdata_o = w_wdata;
                    dmem_be_o    = w_be;
                    mem_stall_o  = ~(mem_mem_write_i & dmem_gnt_i);
                end
            end
            S_REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = r_we;
                dmem_addr_o  = {r_addr[31:2], 2'b00};
                dmem_wdata_o = r_wdata;
                dmem_be_o    = r_be;
                mem_stall_o  = 1'b1;
            end
            S_WAIT_R: mem_stall_o = 1'b1;
            default: ;
        endcase
    end

    assign w_cnt_nxt = r_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_funct3    <= 3'd0;
            r_we        <= 1'b0;
            r_load_data <= 32'd0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_access) begin
                        r_addr   <= mem_alu_result_i;
                        r_wdata  <= w_wdata;
                        r_be     <= w_be;
                        r_funct3 <= mem_funct3_i;
                        r_we     <= mem_mem_write_i;
                        if (!dmem_gnt_i)          r_state <= S_REQ;
                        else if (!mem_mem_write_i) r_state <= S_WAIT_R;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i && r_we) begin
                        r_state <= S_DONE;
                        r_cnt   <= 8'd0;
                    end else if (w_cnt_nxt == TO_LIMIT) begin
                        r_state     <= S_DONE;
                        r_cnt       <= 8'd0;
                        r_timeout   <= 1'b1;
                        r_valid     <= ~r_we;
                        r_load_data <= 32'd0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (dmem_gnt_i) r_state <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (dmem_rvalid_i) begin
                        r_state     <= S_DONE;
                        r_cnt       <= 8'd0;
                        r_valid     <= 1'b1;
                        r_load_data <= w_ext;
                    end else if (w_cnt_nxt == TO_LIMIT) begin
                        r_state     <= S_DONE;
                        r_cnt       <= 8'd0;
                        r_timeout   <= 1'b1;
                        r_valid     <= 1'b1;
                        r_load_data <= 32'd0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_load_data_o  = r_load_data;
    assign mem_load_valid_o = r_valid;
    assign mem_timeout_o    = r_timeout;

`ifdef LSU_PERF_CNT_EN
    logic        w_complete;
    logic [31:0] r_perf_stall, r_perf_access;

    assign w_complete = ((r_state == S_IDLE) & w_access & mem_mem_write_i & dmem_gnt_i)
                      | ((r_state == S_REQ) & dmem_gnt_i & r_we)
                      | ((r_state == S_WAIT_R) & dmem_rvalid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall  <= 32'd0;
            r_perf_access <= 32'd0;
        end else begin
            if (mem_stall_o) r_perf_stall  <= r_perf_stall + 32'd1;
            if (w_complete)  r_perf_access <= r_perf_access + 32'd1;
        end
    end

    assign perf_stall_cnt_o  = r_perf_stall;
    assign perf_access_cnt_o = r_perf_access;
`else
    assign perf_stall_cnt_o  = 32'd0;
    assign perf_access_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboarded bench for mem_stage_lsu: bus handshakes, lane steering, faults, timeout, reset abort.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu, rs2, rdata;
    logic [2:0]  f3;
    logic        rd, wr, gnt, rvalid;
    logic        req, we, lvalid, stall, mis, tmo;
    logic [31:0] addr, wdata, ldata, pstall, pacc;
    logic [3:0]  be;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .mem_alu_result_i(alu), .mem_rs2_data_i(rs2), .mem_funct3_i(f3),
        .mem_mem_read_i(rd), .mem_mem_write_i(wr),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
        .dmem_be_o(be), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .mem_load_data_o(ldata), .mem_load_valid_o(lvalid), .mem_stall_o(stall),
        .mem_misaligned_o(mis), .mem_timeout_o(tmo),
        .perf_stall_cnt_o(pstall), .perf_access_cnt_o(pacc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Drive at posedge+1; the checks that follow sample at the next negedge.
    task automatic drive(input logic r, input logic w, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic g, input logic rv, input logic [31:0] rdt);
        @(posedge clk); #1;
        rd = r; wr = w; f3 = fn; alu = a; rs2 = d; gnt = g; rvalid = rv; rdata = rdt;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (lvalid) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else chk("load_data", ldata, exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; rd = 0; wr = 0; f3 = 0; alu = 0; rs2 = 0; gnt = 0; rvalid = 0; rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ldata", ldata, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_be", {28'd0, be}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // zero-wait SW
        drive(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 0);
        chk("sw_req", {31'd0, req}, 32'd1);
        chk("sw_we", {31'd0, we}, 32'd1);
        chk("sw_be", {28'd0, be}, 32'hF);
        chk("sw_addr", addr, 32'h100);
        chk("sw_wdata", wdata, 32'hDEADBEEF);
        chk("sw_stall", {31'd0, stall}, 32'd0);
        drive(0, 0, 3'b010, 32'h0, 32'h0, 0, 0, 0);
        chk("sw_after_stall", {31'd0, stall}, 32'd0);
        chk("sw_after_req", {31'd0, req}, 32'd0);

        // LB then LBU at 0x203: IDLE(gnt) -> WAIT_R(rvalid) -> DONE
        for (int k = 0; k < 2; k++) begin
            logic [2:0] fn;
            fn = (k == 0) ? 3'b000 : 3'b100;
            exp_q.push_back((k == 0) ? 32'hFFFFFF80 : 32'h00000080);
            drive(1, 0, fn, 32'h203, 0, 1, 0, 0);
            chk("lb_req", {31'd0, req}, 32'd1);
            chk("lb_we", {31'd0, we}, 32'd0);
            chk("lb_be", {28'd0, be}, 32'h8);
            chk("lb_addr", addr, 32'h200);
            chk("lb_stall0", {31'd0, stall}, 32'd1);
            drive(1, 0, fn, 32'h203, 0, 0, 1, 32'h80FFFFFF);
            chk("lb_stall1", {31'd0, stall}, 32'd1);
            chk("lb_wait_req", {31'd0, req}, 32'd0);
            drive(0, 0, fn, 32'h0, 0, 0, 0, 0);
            chk("lb_done_stall", {31'd0, stall}, 32'd0);
            chk("lb_done_valid", {31'd0, lvalid}, 32'd1);
        end

        // SH 0x302, grant in the 4th cycle; inputs perturbed to prove capture
        for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 0, 0, 0);
            else        drive(0, 1, 3'b001, 32'h500, 32'h11111111, (c == 3), 0, 0);
            chk("sh_req", {31'd0, req}, 32'd1);
            chk("sh_be", {28'd0, be}, 32'hC);
            chk("sh_wdata", wdata, 32'hABCDABCD);
            chk("sh_addr", addr, 32'h300);
            chk("sh_stall", {31'd0, stall}, 32'd1);
        end
        drive(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 1, 0, 0);
        chk("sh_done_req", {31'd0, req}, 32'd0);
        chk("sh_done_stall", {31'd0, stall}, 32'd0);
        chk("sh_done_valid", {31'd0, lvalid}, 32'd0);
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 0);

        // faults: misaligned LW, illegal funct3, HU on a store
        drive(1, 0, 3'b010, 32'h101, 0, 1, 0, 0);
        chk("mis_lw", {31'd0, mis}, 32'd1);
        chk("mis_lw_req", {31'd0, req}, 32'd0);
        chk("mis_lw_stall", {31'd0, stall}, 32'd0);
        drive(1, 0, 3'b011, 32'h100, 0, 1, 0, 0);
        chk("mis_f3", {31'd0, mis}, 32'd1);
        chk("mis_f3_req", {31'd0, req}, 32'd0);
        drive(0, 1, 3'b101, 32'h100, 0, 1, 0, 0);
        chk("mis_shu", {31'd0, mis}, 32'd1);
        chk("mis_shu_req", {31'd0, req}, 32'd0);
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 0);
        chk("mis_clear", {31'd0, mis}, 32'd0);

        // reset during WAIT_R, then stray rvalid
        drive(1, 0, 3'b001, 32'h502, 0, 1, 0, 0);
        chk("rw_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; gnt = 0;
        @(negedge clk);
        chk("rw_req", {31'd0, req}, 32'd0);
        chk("rw_stall_rst", {31'd0, stall}, 32'd0);
        chk("rw_ldata", ldata, 32'd0);
        chk("rw_mis", {31'd0, mis}, 32'd0);
        @(posedge clk); #1; rst = 1'b0; rd = 0; rvalid = 1; rdata = 32'h12345678;
        @(negedge clk);
        chk("rw_stray_stall", {31'd0, stall}, 32'd0);
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 0);
        chk("rw_stray_valid", {31'd0, lvalid}, 32'd0);
        chk("rw_stray_ldata", ldata, 32'd0);

        // load first, to leave nonzero data ahead of the timeout
        exp_q.push_back(32'hFFFF8001);
        drive(1, 0, 3'b001, 32'h602, 0, 1, 0, 0);
        drive(1, 0, 3'b001, 32'h602, 0, 0, 1, 32'h8001_0000);
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 0);

        // timeout: IDLE cycle plus 4 cycles in REQ, then DONE with pulse
        exp_q.push_back(32'd0);
        for (int c = 0; c < 5; c++) begin
            drive(1, 0, 3'b010, 32'h400, 0, 0, 0, 0);
            chk("to_stall", {31'd0, stall}, 32'd1);
            chk("to_pulse_early", {31'd0, tmo}, 32'd0);
        end
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 0);
        chk("to_pulse", {31'd0, tmo}, 32'd1);
        chk("to_stall_done", {31'd0, stall}, 32'd0);
        chk("to_ldata", ldata, 32'd0);
        drive(0, 0, 3'b000, 32'h0, 0, 0, 0, 0);
        chk("to_pulse_end", {31'd0, tmo}, 32'd0);
        chk("to_idle_req", {31'd0, req}, 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
